// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: funct3 codes,
// sequencer states and the latched request record.
package data_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      funct3;
    } mem_req_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_legal = 1'b1;
            default:                             f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request/response handshake of both ports plus the single-word memory bus.
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [DATA_WIDTH-1:0] req_addr   [1:0];
    logic [DATA_WIDTH-1:0] req_wdata  [1:0];
    logic [2:0]            req_funct3 [1:0];
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd, mem_be
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd, mem_be
    );
endinterface

// File: rtl/data_mem_arbiter_lane_align.sv
// RV32I lane handling: store byte enables / lane replication, load lane
// extraction with sign or zero extension, and alignment checking.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mem_rd,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned
);
    logic [15:0] shifted;

    always_comb begin
        shifted    = 16'(mem_rd >> {addr_lo, 3'b000});
        be         = 4'b0000;
        wd         = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        // funct3[2] selects zero extension for the byte/halfword loads
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wd        = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wd         = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, shifted}
                                       : {{16{shifted[15]}}, shifted};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                be         = 4'b1111;
                wd         = wdata;
                rdata_ext  = mem_rd;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter and single-access sequencer for the 128 KiB
// data memory: grant, one memory cycle, then hold the response until consumed.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ADDR_LIMIT = 32'h0001FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus
);
    state_t                state, state_nx;
    logic                  last_grant;
    logic                  id_q;
    mem_req_t              req_q;
    mem_req_t              cand;
    logic                  any_req, win, illegal;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [2:0]            sel_f3;
    logic [1:0]            sel_lo;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wd, al_rdata;
    logic                  al_misaligned;

    logic [1:0]            req_ready, rsp_valid;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_addr, mem_wd;

    assign any_req = |bus.req_valid;
    // With both ports valid the one not granted last time wins
    assign win = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];

    always_comb begin
        cand.we     = bus.req_we[win];
        cand.addr   = bus.req_addr[win];
        cand.wdata  = bus.req_wdata[win];
        cand.funct3 = bus.req_funct3[win];
    end

    // The aligner checks the incoming request in IDLE and drives the access from the latch afterwards
    assign sel_f3    = (state == IDLE) ? cand.funct3     : req_q.funct3;
    assign sel_lo    = (state == IDLE) ? cand.addr[1:0]  : req_q.addr[1:0];
    assign sel_wdata = (state == IDLE) ? cand.wdata      : req_q.wdata;

    mem_lane_align u_align (
        .funct3     (sel_f3),
        .addr_lo    (sel_lo),
        .wdata      (sel_wdata),
        .mem_rd     (bus.mem_rd),
        .be         (al_be),
        .wd         (al_wd),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    assign illegal = al_misaligned | ~f3_legal(cand.funct3) | (cand.addr > ADDR_LIMIT);

    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wd    = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[win] = 1'b1;
                    state_nx       = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = {req_q.addr[DATA_WIDTH-1:2], 2'b00};
                if (req_q.we) begin
                    mem_we = 1'b1;
                    mem_be = al_be;
                    mem_wd = al_wd;
                end
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (bus.rsp_ready[id_q]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                last_grant <= win;
                id_q       <= win;
                rsp_err    <= illegal;
                rsp_rdata  <= '0;
            end else if (state == ACCESS) begin
                rsp_rdata <= req_q.we ? '0 : al_rdata;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Request fields are plain data: only meaningful once state leaves IDLE
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) req_q <= cand;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wd    = mem_wd;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stores, extended loads, round-robin
// alternation, illegal requests and an asynchronous reset during a store.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchecks = 0;
    int   nerr = 0;

    data_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_LIMIT(32'h0001FFFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge, check the grant, return 1 ns after the handshake edge
    task automatic issue(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        @(negedge clk);
        bus.req_we[p]     = we;
        bus.req_addr[p]   = addr;
        bus.req_wdata[p]  = wdata;
        bus.req_funct3[p] = f3;
        bus.req_valid[p]  = 1'b1;
        #1;
        chk("grant", {30'b0, bus.req_ready}, 32'(1 << p));
        @(posedge clk);
        #1;
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic finish_rsp(input int p);
        bus.rsp_ready[p] = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready[p] = 1'b0;
        chk("rsp_drop", {30'b0, bus.rsp_valid}, 32'h0);
    endtask

    task automatic load_case(input string tag, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] exp);
        issue(0, 1'b0, addr, 32'h0, f3);
        chk({tag, "_we"}, {31'b0, bus.mem_we}, 32'h0);
        chk({tag, "_be"}, {28'b0, bus.mem_be}, 32'h0);
        chk({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, {30'b0, bus.rsp_valid}, 32'h1);
        chk({tag, "_rdata"}, bus.rsp_rdata, exp);
        chk({tag, "_err"}, {31'b0, bus.rsp_err}, 32'h0);
        finish_rsp(0);
    endtask

    task automatic illegal_case(input string tag, input int p, input logic we,
                                input logic [31:0] addr, input logic [2:0] f3);
        issue(p, we, addr, 32'hFFFF_FFFF, f3);
        chk({tag, "_we"}, {31'b0, bus.mem_we}, 32'h0);
        chk({tag, "_valid"}, {30'b0, bus.rsp_valid}, 32'(1 << p));
        chk({tag, "_err"}, {31'b0, bus.rsp_err}, 32'h1);
        chk({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
        finish_rsp(p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_we    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            bus.req_addr[i]   = '0;
            bus.req_wdata[i]  = '0;
            bus.req_funct3[i] = '0;
        end
        bus.mem_rd = 32'h80FF0011;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {30'b0, bus.req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'h0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store from port 0
        issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
        chk("sw_we", {31'b0, bus.mem_we}, 32'h1);
        chk("sw_be", {28'b0, bus.mem_be}, 32'hF);
        chk("sw_addr", bus.mem_addr, 32'h100);
        chk("sw_wd", bus.mem_wd, 32'hDEADBEEF);
        chk("sw_early_valid", {30'b0, bus.rsp_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("sw_valid", {30'b0, bus.rsp_valid}, 32'h1);
        chk("sw_err", {31'b0, bus.rsp_err}, 32'h0);
        chk("sw_rdata", bus.rsp_rdata, 32'h0);
        chk("sw_we_off", {31'b0, bus.mem_we}, 32'h0);
        finish_rsp(0);

        // Loads against mem_rd = 0x80FF0011
        load_case("lb", 32'h103, 3'b000, 32'hFFFFFF80);
        load_case("lbu", 32'h103, 3'b100, 32'h00000080);
        load_case("lhu", 32'h102, 3'b101, 32'h000080FF);
        load_case("lh", 32'h102, 3'b001, 32'hFFFF80FF);
        load_case("lb0", 32'h100, 3'b000, 32'h00000011);
        load_case("lw", 32'h100, 3'b010, 32'h80FF0011);

        // Halfword store from port 1
        issue(1, 1'b1, 32'h206, 32'h1234ABCD, 3'b001);
        chk("sh_be", {28'b0, bus.mem_be}, 32'hC);
        chk("sh_wd", bus.mem_wd, 32'hABCDABCD);
        chk("sh_addr", bus.mem_addr, 32'h204);
        @(posedge clk);
        #1;
        chk("sh_valid", {30'b0, bus.rsp_valid}, 32'h2);
        finish_rsp(1);

        // Contention with rsp_ready held high: grants alternate 0,1,0,1
        @(negedge clk);
        bus.req_we         = 2'b00;
        bus.req_addr[0]    = 32'h10;
        bus.req_addr[1]    = 32'h20;
        bus.req_funct3[0]  = 3'b010;
        bus.req_funct3[1]  = 3'b010;
        bus.rsp_ready      = 2'b11;
        bus.req_valid      = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", {30'b0, bus.req_ready}, ((k % 2) == 0) ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            chk("rr_addr", bus.mem_addr, ((k % 2) == 0) ? 32'h10 : 32'h20);
            @(posedge clk);
            #1;
            chk("rr_valid", {30'b0, bus.rsp_valid}, ((k % 2) == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata", bus.rsp_rdata, 32'h80FF0011);
            @(posedge clk);
            #1;
            if (k == 3) bus.req_valid = 2'b00;
        end
        bus.rsp_ready = 2'b00;
        chk("rr_idle", {30'b0, bus.rsp_valid}, 32'h0);

        // Illegal requests: no memory activity, error response with zero data
        illegal_case("lw_mis", 0, 1'b0, 32'h102, 3'b010);
        illegal_case("sb_range", 0, 1'b1, 32'h20000, 3'b000);
        illegal_case("sh_mis", 1, 1'b1, 32'h201, 3'b001);
        illegal_case("bad_f3", 1, 1'b0, 32'h100, 3'b011);
        illegal_case("lhu_mis", 0, 1'b0, 32'h103, 3'b101);

        // Async reset in the ACCESS cycle of a store; last grant went to port 0
        issue(0, 1'b1, 32'h300, 32'h55AA55AA, 3'b010);
        chk("rst_store_we", {31'b0, bus.mem_we}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_async_be", {28'b0, bus.mem_be}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_no_valid", {30'b0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {30'b0, bus.rsp_valid}, 32'h0);
        chk("post_rst_we", {31'b0, bus.mem_we}, 32'h0);
        @(negedge clk);
        bus.req_we        = 2'b00;
        bus.req_funct3[0] = 3'b010;
        bus.req_funct3[1] = 3'b010;
        bus.req_addr[0]   = 32'h40;
        bus.req_addr[1]   = 32'h80;
        bus.req_valid     = 2'b11;
        #1;
        chk("post_rst_grant", {30'b0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        chk("post_rst_addr", bus.mem_addr, 32'h40);
        @(posedge clk);
        #1;
        chk("post_rst_rsp", {30'b0, bus.rsp_valid}, 32'h1);
        finish_rsp(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-port arbiter and access sequencer for the 128 KiB data memory (0x00000000–0x0001FFFF).
- Port 0 is the CPU load/store path; port 1 is the program loader / debug path.
- Grants one requester at a time (round-robin) and performs the RV32I width handling: byte enables and lane placement on stores, lane extraction with sign/zero extension on loads.
- Rejects misaligned and out-of-range accesses.

Parameters:
DATA_WIDTH, 32, data/address width.
ADDR_LIMIT, 32'h0001FFFF, highest legal byte address.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  request valid per port [p]
req_ready  out  2  request accepted per port (one-hot or zero)
req_we  in  2  1 = store, 0 = load, per port
req_addr  in  2x32  byte address per port (unpacked [1:0])
req_wdata  in  2x32  store data per port, value in bits [7:0]/[15:0]/[31:0]
req_funct3  in  2x3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  out  2  response valid, one-hot to the granted port
rsp_ready  in  2  response consumed, per port
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, out-of-range or illegal funct3
mem_we  out  1  memory write enable
mem_addr  out  32  word-aligned address (addr[1:0] forced to 00)
mem_wd  out  32  store data placed in lanes
mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
mem_rd  in  32  memory word, combinational read of mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state = IDLE, last_grant = 1 (port 0 wins first), all outputs 0.
- IDLE:
  - req_ready is asserted combinationally to the winner when any req_valid is high.
  - Winner is the only valid port; if both are valid, the port != last_grant.
  - On handshake: latch addr, wdata, funct3, we and the port id; update last_grant.
  - Go to ACCESS, or straight to RESP with err = 1 if the request is illegal.
- Illegal request (no memory activity at all):
  - H/HU with addr[0] != 0;
  - W with addr[1:0] != 00;
  - addr > ADDR_LIMIT;
  - funct3 not one of the five listed codes.
- ACCESS (exactly 1 cycle):
  - mem_addr = {addr[31:2], 2'b00}.
  - Store: mem_we = 1.
    - B: mem_be = 0001 << addr[1:0]; byte replicated to all lanes.
    - H: mem_be = 0011 << addr[1:0]; halfword replicated to both halves.
    - W: mem_be = 1111; mem_wd = wdata.
  - Load: mem_we = 0, mem_be = 0. Select the lane from mem_rd using addr[1:0]; sign-extend B/H, zero-extend BU/HU; register the result into rsp_rdata.
  - Go to RESP.
- RESP:
  - rsp_valid[id] = 1; rsp_rdata and rsp_err are held stable.
  - Leave to IDLE on rsp_ready[id]. No new grant is made in that same cycle.
- Latency: handshake at cycle N, memory access at N+1, rsp_valid from N+2. Legal accesses have a throughput of one per 3 cycles.
- Output timing:
  - mem_we, mem_be and mem_addr are combinational from state and latched fields; they are 0 outside ACCESS.
  - No request is ever lost: a requester holds req_valid until it sees req_ready.
- Async reset mid-ACCESS: mem_we drops immediately and the state returns to IDLE. A partially issued store is not repeated. A pending response is discarded.
- Simultaneous valid requests on consecutive transactions alternate strictly, so there is no starvation.
- rsp_ready held high in advance is legal; RESP then lasts exactly one cycle.

Decomposition:
- Package data_mem_pkg:
  - funct3 localparams F3_LB/LH/LW/LBU/LHU;
  - typedef enum state_t {IDLE, ACCESS, RESP};
  - typedef struct mem_req_t {we, addr, wdata, funct3}.
- Sub-module mem_lane_align (combinational) maps funct3, addr[1:0], wdata and mem_rd to mem_be, mem_wd, rdata_ext and misaligned. It is shared by the store and load paths.

Test Plan:
- Port 0 SW addr 0x100, wdata 0xDEADBEEF -> ACCESS cycle shows mem_we = 1, mem_be = 1111, mem_addr = 0x100; rsp_valid[0] at N+2, rsp_err = 0.
- Port 0 LB addr 0x103 with mem_rd = 0x80FF0011 -> rsp_rdata = 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- Port 1 SH addr 0x206, wdata 0x1234ABCD -> mem_be = 1100, mem_wd = 0xABCDABCD.
- Both ports valid for 4 back-to-back transactions -> grants in order 0, 1, 0, 1; each rsp_valid goes only to its own port.
- LW addr 0x102, then SB addr 0x20000 -> rsp_err = 1, mem_we never asserted, rsp_rdata = 0.
- rst_n pulsed low during the ACCESS cycle of a store -> mem_we falls asynchronously, no rsp_valid; after release port 0 wins the first grant.
